// File: rtl/dbg_bus_byte_bridge.sv
// Word-to-byte bridge: serialises each word write/read from the debug bus master
// into DATA_BYTES single-byte accesses on a 1-cycle-latency byte memory.
module dbg_bus_byte_bridge #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_BYTES = 4,
    parameter int BIG_ENDIAN = 0
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     wreq,
    output logic                                     wgnt,
    input  logic [ADDR_WIDTH-1:0]                    waddr,
    input  logic [8*DATA_BYTES-1:0]                  wdata,
    input  logic                                     rreq,
    output logic                                     rgnt,
    input  logic [ADDR_WIDTH-1:0]                    raddr,
    output logic [8*DATA_BYTES-1:0]                  rdata,
    output logic                                     busy,
    output logic                                     mem_we,
    output logic [ADDR_WIDTH+$clog2(DATA_BYTES)-1:0] mem_addr,
    output logic [7:0]                               mem_wdata,
    input  logic [7:0]                               mem_rdata
);

    localparam int DW = 8 * DATA_BYTES;
    localparam int CW = $clog2(DATA_BYTES);
    localparam int BW = ADDR_WIDTH + CW;
    localparam logic [CW-1:0] LAST = CW'(DATA_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR      = 3'd1,
        S_RD      = 3'd2,
        S_RD_LAST = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DW-1:0]           wbuf_q;
    logic [DW-1:0]           asm_q;
    logic [CW-1:0]           cnt_q;
    logic                    wgnt_q;
    logic                    rgnt_q;
    logic                    busy_q;
    logic                    mem_we_q;
    logic [BW-1:0]           mem_addr_q;
    logic [7:0]              mem_wdata_q;
    logic [DW-1:0]           rdata_q;

    logic [CW-1:0]           cap_idx_d;
    logic [CW-1:0]           cnt_nxt_d;
    logic [DW-1:0]           asm_d;

    // Byte k of a word lives in lane k (little endian) or lane DATA_BYTES-1-k (big endian).
    function automatic logic [CW-1:0] lane_of(input logic [CW-1:0] k);
        logic [CW-1:0] lane;
        if (BIG_ENDIAN != 0) begin
            lane = LAST - k;
        end else begin
            lane = k;
        end
        return lane;
    endfunction

    function automatic logic [7:0] get_byte(input logic [DW-1:0] w, input logic [CW-1:0] k);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (CW'(i) == lane_of(k)) begin
                b = w[8*i +: 8];
            end
        end
        return b;
    endfunction

    function automatic logic [DW-1:0] put_byte(input logic [DW-1:0] w, input logic [CW-1:0] k,
                                               input logic [7:0] b);
        logic [DW-1:0] r;
        r = w;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (CW'(i) == lane_of(k)) begin
                r[8*i +: 8] = b;
            end
        end
        return r;
    endfunction

    // Returning byte index: memory data lags the presented address by one cycle.
    always_comb begin
        if (state_q == S_RD_LAST) begin
            cap_idx_d = cnt_q;
        end else begin
            cap_idx_d = cnt_q - CW'(1);
        end
        cnt_nxt_d = cnt_q + CW'(1);
        asm_d     = put_byte(asm_q, cap_idx_d, mem_rdata);
    end

    // Bridge FSM with all bus and memory outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wbuf_q      <= '0;
            asm_q       <= '0;
            cnt_q       <= '0;
            wgnt_q      <= 1'b0;
            rgnt_q      <= 1'b0;
            busy_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h00;
            rdata_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Write wins a tie; the master keeps the read request up meanwhile.
                    if (wreq) begin
                        addr_q      <= waddr;
                        wbuf_q      <= wdata;
                        cnt_q       <= '0;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= {waddr, {CW{1'b0}}};
                        mem_wdata_q <= get_byte(wdata, '0);
                        busy_q      <= 1'b1;
                        state_q     <= S_WR;
                    end else if (rreq) begin
                        addr_q     <= raddr;
                        asm_q      <= '0;
                        cnt_q      <= '0;
                        mem_addr_q <= {raddr, {CW{1'b0}}};
                        busy_q     <= 1'b1;
                        state_q    <= S_RD;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                S_WR: begin
                    if (cnt_q == LAST) begin
                        mem_we_q <= 1'b0;
                        wgnt_q   <= 1'b0;
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q       <= cnt_nxt_d;
                        mem_addr_q  <= {addr_q, cnt_nxt_d};
                        mem_wdata_q <= get_byte(wbuf_q, cnt_nxt_d);
                        wgnt_q      <= (cnt_nxt_d == LAST);
                    end
                end
                S_RD: begin
                    if (cnt_q != '0) begin
                        asm_q <= asm_d;
                    end
                    if (cnt_q == LAST) begin
                        rgnt_q  <= 1'b1;
                        state_q <= S_RD_LAST;
                    end else begin
                        cnt_q      <= cnt_nxt_d;
                        mem_addr_q <= {addr_q, cnt_nxt_d};
                    end
                end
                S_RD_LAST: begin
                    asm_q   <= asm_d;
                    rdata_q <= asm_d;
                    rgnt_q  <= 1'b0;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    wgnt_q   <= 1'b0;
                    rgnt_q   <= 1'b0;
                    mem_we_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign wgnt      = wgnt_q;
    assign rgnt      = rgnt_q;
    assign busy      = busy_q;
    assign rdata     = rdata_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dbg_bus_byte_bridge.sv
// Self-checking bench for dbg_bus_byte_bridge: little-endian instance with a byte-write
// scoreboard and grant timing checks, plus a big-endian instance for lane ordering.
module tb_dbg_bus_byte_bridge;

    logic        clk;
    logic        rst;
    logic        wreq, rreq, wgnt, rgnt, busy, mem_we;
    logic [7:0]  waddr, raddr, mem_wdata, mem_rdata;
    logic [31:0] wdata, rdata;
    logic [9:0]  mem_addr;

    logic        be_wreq, be_rreq, be_wgnt, be_rgnt, be_busy, be_mem_we;
    logic [7:0]  be_waddr, be_raddr, be_mem_wdata, be_mem_rdata;
    logic [31:0] be_wdata, be_rdata;
    logic [9:0]  be_mem_addr;

    logic [7:0]  mem0 [0:1023];
    logic [7:0]  mem1 [0:1023];

    typedef struct packed {
        logic [31:0] cyc;
        logic [9:0]  addr;
        logic [7:0]  data;
    } wr_t;

    wr_t exp_wr[$];
    wr_t obs_wr[$];
    int  obs_wg[$];
    int  both_cnt;
    int  cyc;
    int  checks;
    int  errors;

    dbg_bus_byte_bridge #(.ADDR_WIDTH(8), .DATA_BYTES(4), .BIG_ENDIAN(0)) dut (
        .clk(clk), .rst(rst),
        .wreq(wreq), .wgnt(wgnt), .waddr(waddr), .wdata(wdata),
        .rreq(rreq), .rgnt(rgnt), .raddr(raddr), .rdata(rdata),
        .busy(busy), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    dbg_bus_byte_bridge #(.ADDR_WIDTH(8), .DATA_BYTES(4), .BIG_ENDIAN(1)) dut_be (
        .clk(clk), .rst(rst),
        .wreq(be_wreq), .wgnt(be_wgnt), .waddr(be_waddr), .wdata(be_wdata),
        .rreq(be_rreq), .rgnt(be_rgnt), .raddr(be_raddr), .rdata(be_rdata),
        .busy(be_busy), .mem_we(be_mem_we), .mem_addr(be_mem_addr),
        .mem_wdata(be_mem_wdata), .mem_rdata(be_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Byte memories with one cycle of read latency.
    always @(posedge clk) begin
        if (mem_we) mem0[mem_addr] <= mem_wdata;
        mem_rdata <= mem0[mem_addr];
        if (be_mem_we) mem1[be_mem_addr] <= be_mem_wdata;
        be_mem_rdata <= mem1[be_mem_addr];
    end

    // Observation log for the little-endian instance.
    always @(negedge clk) begin
        if (mem_we) obs_wr.push_back(wr_t'{32'(cyc), mem_addr, mem_wdata});
        if (wgnt) obs_wg.push_back(cyc);
        if (wgnt && rgnt) both_cnt = both_cnt + 1;
    end

    // Expected byte writes of one LE word access accepted in cycle t.
    task automatic push_word(input int t, input logic [7:0] wa, input logic [31:0] d);
        for (int k = 0; k < 4; k++) begin
            exp_wr.push_back(wr_t'{32'(t + 1 + k), {wa, 2'b00} + 10'(k), d[8*k +: 8]});
        end
    endtask

    // Master write: request held until wgnt, dropped the cycle after.
    task automatic mw(input logic [7:0] a, input logic [31:0] d, output int g);
        wreq = 1'b1; waddr = a; wdata = d;
        g = -1;
        for (int i = 0; i < 40 && g < 0; i++) begin
            @(negedge clk);
            if (wgnt) g = cyc;
            @(posedge clk); #1;
        end
        wreq = 1'b0;
    endtask

    task automatic mr(input logic [7:0] a, output int g);
        rreq = 1'b1; raddr = a;
        g = -1;
        for (int i = 0; i < 40 && g < 0; i++) begin
            @(negedge clk);
            if (rgnt) g = cyc;
            @(posedge clk); #1;
        end
        rreq = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 7;
        if (wgnt !== 1'b0) begin errors++; $display("FAIL reset_wgnt: got %b want 0", wgnt); end
        if (rgnt !== 1'b0) begin errors++; $display("FAIL reset_rgnt: got %b want 0", rgnt); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        if (mem_addr !== 10'h000) begin errors++; $display("FAIL reset_mem_addr: got %h want 000", mem_addr); end
        if (mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_mem_wdata: got %h want 00", mem_wdata); end
        if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_write;
        int t0, g;
        exp_wr.delete(); obs_wr.delete(); obs_wg.delete();
        t0 = cyc;
        push_word(t0, 8'h12, 32'hA1B2C3D4);
        mw(8'h12, 32'hA1B2C3D4, g);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL write_busy_done: got %b want 1", busy); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_idle: got %b want 0", busy); end
        checks += 2;
        if (g !== t0 + 4) begin errors++; $display("FAIL write_wgnt_cycle: got %0d want %0d", g, t0 + 4); end
        if (obs_wg.size() !== 1) begin errors++; $display("FAIL write_wgnt_count: got %0d want 1", obs_wg.size()); end
        while (exp_wr.size() > 0) begin
            wr_t e, o;
            e = exp_wr.pop_front();
            checks++;
            if (obs_wr.size() == 0) begin errors++; $display("FAIL write_byte_missing: got none want %h", e); end
            else begin
                o = obs_wr.pop_front();
                if (o !== e) begin errors++; $display("FAIL write_byte: got %h want %h", o, e); end
            end
        end
        checks++;
        if (obs_wr.size() != 0) begin errors++; $display("FAIL write_extra_bytes: got %0d want 0", obs_wr.size()); end
        @(posedge clk); #1;
    endtask

    task automatic test_read;
        int t0, g;
        t0 = cyc;
        mr(8'h12, g);
        @(negedge clk);
        checks += 2;
        if (g !== t0 + 5) begin errors++; $display("FAIL read_rgnt_cycle: got %0d want %0d", g, t0 + 5); end
        if (rdata !== 32'hA1B2C3D4) begin errors++; $display("FAIL read_rdata: got %h want a1b2c3d4", rdata); end
        repeat (4) @(negedge clk);
        checks++;
        if (rdata !== 32'hA1B2C3D4) begin errors++; $display("FAIL read_rdata_hold: got %h want a1b2c3d4", rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_simultaneous;
        int t0, gw, gr;
        logic [31:0] rd_pre;
        exp_wr.delete(); obs_wr.delete(); obs_wg.delete();
        both_cnt = 0;
        rd_pre = 32'h0;
        t0 = cyc;
        push_word(t0, 8'h05, 32'hDEADBEEF);
        wreq = 1'b1; rreq = 1'b1; waddr = 8'h05; raddr = 8'h05; wdata = 32'hDEADBEEF;
        gw = -1; gr = -1;
        for (int i = 0; i < 60 && gr < 0; i++) begin
            @(negedge clk);
            if (wgnt) gw = cyc;
            if (rgnt) gr = cyc;
            if (cyc == t0 + 6) rd_pre = rdata;
            @(posedge clk); #1;
            if (gw >= 0) wreq = 1'b0;
        end
        wreq = 1'b0; rreq = 1'b0;
        @(negedge clk);
        checks += 5;
        if (gw !== t0 + 4) begin errors++; $display("FAIL simul_wgnt_cycle: got %0d want %0d", gw, t0 + 4); end
        if (gr !== t0 + 11) begin errors++; $display("FAIL simul_rgnt_cycle: got %0d want %0d", gr, t0 + 11); end
        if (rd_pre !== 32'hA1B2C3D4) begin errors++; $display("FAIL simul_rdata_before: got %h want a1b2c3d4", rd_pre); end
        if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL simul_rdata: got %h want deadbeef", rdata); end
        if (both_cnt !== 0) begin errors++; $display("FAIL simul_coincident_gnt: got %0d want 0", both_cnt); end
        while (exp_wr.size() > 0) begin
            wr_t e, o;
            e = exp_wr.pop_front();
            checks++;
            if (obs_wr.size() == 0) begin errors++; $display("FAIL simul_byte_missing: got none want %h", e); end
            else begin
                o = obs_wr.pop_front();
                if (o !== e) begin errors++; $display("FAIL simul_byte: got %h want %h", o, e); end
            end
        end
        checks++;
        if (obs_wr.size() != 0) begin errors++; $display("FAIL simul_extra_bytes: got %0d want 0", obs_wr.size()); end
        @(posedge clk); #1;
    endtask

    task automatic test_big_endian;
        logic [7:0] exp_b [4];
        int g;
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        be_wreq = 1'b1; be_waddr = 8'h00; be_wdata = 32'h11223344;
        g = -1;
        for (int i = 0; i < 40 && g < 0; i++) begin
            @(negedge clk);
            if (be_wgnt) g = cyc;
            @(posedge clk); #1;
        end
        be_wreq = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (mem1[k] !== exp_b[k]) begin errors++; $display("FAIL be_byte%0d: got %h want %h", k, mem1[k], exp_b[k]); end
        end
        be_rreq = 1'b1; be_raddr = 8'h00;
        g = -1;
        for (int i = 0; i < 40 && g < 0; i++) begin
            @(negedge clk);
            if (be_rgnt) g = cyc;
            @(posedge clk); #1;
        end
        be_rreq = 1'b0;
        @(negedge clk);
        checks++;
        if (be_rdata !== 32'h11223344) begin errors++; $display("FAIL be_rdata: got %h want 11223344", be_rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int g, t0;
        wreq = 1'b1; waddr = 8'h30; wdata = 32'h55667788;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; wreq = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_wr.delete(); obs_wr.delete(); obs_wg.delete();
        @(negedge clk);
        checks += 4;
        if (mem_we !== 1'b0) begin errors++; $display("FAIL rstmid_mem_we: got %b want 0", mem_we); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        if (wgnt !== 1'b0) begin errors++; $display("FAIL rstmid_wgnt: got %b want 0", wgnt); end
        if (rdata !== 32'h0) begin errors++; $display("FAIL rstmid_rdata: got %h want 0", rdata); end
        repeat (4) begin @(posedge clk); #1; end
        checks += 2;
        if (obs_wg.size() != 0) begin errors++; $display("FAIL rstmid_late_wgnt: got %0d want 0", obs_wg.size()); end
        if (obs_wr.size() != 0) begin errors++; $display("FAIL rstmid_late_write: got %0d want 0", obs_wr.size()); end
        t0 = cyc;
        push_word(t0, 8'h01, 32'h0BADF00D);
        mw(8'h01, 32'h0BADF00D, g);
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (g !== t0 + 4) begin errors++; $display("FAIL rstmid_next_wgnt: got %0d want %0d", g, t0 + 4); end
        while (exp_wr.size() > 0) begin
            wr_t e, o;
            e = exp_wr.pop_front();
            checks++;
            if (obs_wr.size() == 0) begin errors++; $display("FAIL rstmid_byte_missing: got none want %h", e); end
            else begin
                o = obs_wr.pop_front();
                if (o !== e) begin errors++; $display("FAIL rstmid_byte: got %h want %h", o, e); end
            end
        end
    endtask

    task automatic test_back_to_back;
        int t0, g, g2;
        exp_wr.delete(); obs_wr.delete(); obs_wg.delete();
        both_cnt = 0;
        t0 = cyc;
        push_word(t0, 8'hFF, 32'hCAFEF00D);
        wreq = 1'b1; waddr = 8'hFF; wdata = 32'hCAFEF00D;
        g = -1;
        for (int i = 0; i < 40 && g < 0; i++) begin
            @(negedge clk);
            if (wgnt) g = cyc;
            @(posedge clk); #1;
        end
        // wreq stays up through the DONE cycle, then a new word is presented.
        @(posedge clk); #1;
        waddr = 8'h40; wdata = 32'h01020304;
        push_word(g + 2, 8'h40, 32'h01020304);
        g2 = -1;
        for (int i = 0; i < 40 && g2 < 0; i++) begin
            @(negedge clk);
            if (wgnt) g2 = cyc;
            @(posedge clk); #1;
        end
        wreq = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        checks += 4;
        if (g !== t0 + 4) begin errors++; $display("FAIL b2b_first_wgnt: got %0d want %0d", g, t0 + 4); end
        if (g2 !== g + 6) begin errors++; $display("FAIL b2b_second_wgnt: got %0d want %0d", g2, g + 6); end
        if (obs_wg.size() !== 2) begin errors++; $display("FAIL b2b_wgnt_count: got %0d want 2", obs_wg.size()); end
        if (both_cnt !== 0) begin errors++; $display("FAIL b2b_coincident_gnt: got %0d want 0", both_cnt); end
        while (exp_wr.size() > 0) begin
            wr_t e, o;
            e = exp_wr.pop_front();
            checks++;
            if (obs_wr.size() == 0) begin errors++; $display("FAIL b2b_byte_missing: got none want %h", e); end
            else begin
                o = obs_wr.pop_front();
                if (o !== e) begin errors++; $display("FAIL b2b_byte: got %h want %h", o, e); end
            end
        end
        checks++;
        if (obs_wr.size() != 0) begin errors++; $display("FAIL b2b_extra_bytes: got %0d want 0", obs_wr.size()); end
    endtask

    initial begin
        cyc = 0; checks = 0; errors = 0; both_cnt = 0;
        rst = 1'b1;
        wreq = 1'b0; rreq = 1'b0; waddr = 8'h00; raddr = 8'h00; wdata = 32'h0;
        be_wreq = 1'b0; be_rreq = 1'b0; be_waddr = 8'h00; be_raddr = 8'h00; be_wdata = 32'h0;
        test_reset;
        test_write;
        test_read;
        test_simultaneous;
        test_big_endian;
        test_reset_mid;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
